hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Stall/bubble controller for the 5-stage MIPS pipeline. Tracks a shadow copy of the destination register and remaining result latency (Tnew) of the instructions in E and M. Compares them against the source registers and first-use time (Tuse) of the instruction in D. Drives the freeze of PC/FD and the clear of the D/E pipeline register; optionally also serialises mult/div with a busy countdown.

## Interface
- No parameters.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all internal state
- rs_D  in  5  rs field of instruction in D
- rt_D  in  5  rt field of instruction in D
- tuse_rs_D  in  2  cycles until rs is consumed (0 = D, 1 = E, 2 = M, 3 = not used)
- tuse_rt_D  in  2  same for rt
- wa_D  in  5  GRF write address of instruction in D (0 = no write)
- tnew_D  in  2  Tnew the instruction will carry on entering E (0..2; ALU = 1, load = 2, jal/lui = 0)
- md_start_D  in  1  instruction in D is mult/multu/div/divu
- md_div_D  in  1  with md_start_D: divide (1) vs multiply (0)
- md_use_D  in  1  instruction in D touches HI/LO (mfhi/mflo/mthi/mtlo/mult*/div*)
- stall  out  1  freeze PC and F/D register this cycle
- clr_E  out  1  load bubble into D/E register at next edge (== stall)
- md_busy  out  1  mult/div unit occupied (E-start or countdown nonzero)

## Operation
- Shadow state: wa_E, tnew_E, md_start_E, md_div_E, wa_M, tnew_M, md_cnt[3:0]. All zero after reset.
- Every clk edge, no stall: E ← (wa_D, tnew_D, md_start_D, md_div_D); M ← (wa_E, sat(tnew_E−1)), where sat floors at 0.
- Every clk edge, stall: E ← bubble (all 0); M advances as above.
- Register hazard on rs: rs_D≠0 and tuse_rs_D≠3 and ((wa_E==rs_D and tnew_E>tuse_rs_D) or (wa_M==rs_D and tnew_M>tuse_rs_D)). Same for rt. Operands with Tnew ≤ Tuse are forwarded, not stalled.
- MD hazard: md_use_D and md_busy.
- stall = rs hazard | rt hazard | MD hazard; clr_E = stall.
- md_cnt: when md_start_E=1 at an edge, load 5 (mult) or 10 (div); else decrement if nonzero. md_busy = md_start_E | (md_cnt≠0).
- Back-to-back mult/div: second one stalls in D until md_busy falls, then issues normally.

## Timing
- stall, clr_E, md_busy are combinational from current shadow state and D inputs; same-cycle response, zero latency.
- Shadow state updates on posedge clk only; reset has priority over all updates.
- Reset mid-countdown: md_cnt=0, shadows cleared; stall=0 in the cycle after reset unless D inputs alone cause it (they cannot; all shadow fields are 0).
- Write to $0 (wa=0) never produces a hazard, regardless of Tnew.
- Simultaneous rs and rt hazards, or register and MD hazards: single stall; no extra cycles.
- Load-use against D-stage Tuse 0 (branch/jr): 2 stall cycles; Tuse 1: 1 stall cycle.

## Configuration
- HAZARD_MD_EN defined: mult/div tracking as above (md_start_E, md_div_E, md_cnt, MD hazard).
- Not defined: md_start_D, md_div_D and md_use_D are ignored; md_busy tied 0; no md_cnt or md shadow flops; stall is the register hazard only.

## Test plan
- lw wa=1 tnew=2, then addu rs=1 tuse_rs=1: stall=1 for exactly 1 cycle with clr_E=1, then E=bubble, M wa=1 tnew=1, stall=0.
- lw wa=1 tnew=2, then beq rs=1 tuse_rs=0: stall=1 for 2 consecutive cycles, 0 on the third.
- addu wa=0 tnew=1, then instruction rs=0 tuse=0: stall stays 0; operand with tuse_rt=3 matching wa_E also never stalls.
- (HAZARD_MD_EN) mult then mflo immediately: stall asserted for 6 cycles (1 E + 5 countdown); divu then mfhi: 11 cycles; md_busy mirrors them.
- (HAZARD_MD_EN) div issued, reset pulsed at md_cnt=7: next cycle md_cnt=0, md_busy=0, a pending mflo does not stall.
- Random dependent-instruction stream vs. golden Tuse/Tnew model: stall and clr_E match every cycle; no RAW value mismatch in the GRF trace.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble controller tracking E/M destination shadows against D-stage Tuse.
// Define HAZARD_MD_EN to also serialise mult/div via a busy countdown.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] wa_D,
  input  logic [1:0] tnew_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic       clr_E,
  output logic       md_busy
);
  logic [4:0] wa_E, wa_M;
  logic [1:0] tnew_E, tnew_M;
  logic       hz_rs, hz_rt, hz_md;
  always_comb begin
    hz_rs = rs_D != 5'd0 && tuse_rs_D != 2'd3 &&
            ((wa_E == rs_D && tnew_E > tuse_rs_D) || (wa_M == rs_D && tnew_M > tuse_rs_D));
    hz_rt = rt_D != 5'd0 && tuse_rt_D != 2'd3 &&
            ((wa_E == rt_D && tnew_E > tuse_rt_D) || (wa_M == rt_D && tnew_M > tuse_rt_D));
    stall = hz_rs | hz_rt | hz_md;
    clr_E = stall;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wa_E   <= 5'd0;
      tnew_E <= 2'd0;
      wa_M   <= 5'd0;
      tnew_M <= 2'd0;
    end else begin
      wa_E   <= stall ? 5'd0 : wa_D;
      tnew_E <= stall ? 2'd0 : tnew_D;
      wa_M   <= wa_E;
      tnew_M <= tnew_E == 2'd0 ? 2'd0 : tnew_E - 2'd1;
    end
  end
`ifdef HAZARD_MD_EN
  logic       md_start_E, md_div_E;
  logic [3:0] md_cnt;
  always_comb begin
    md_busy = md_start_E | (md_cnt != 4'd0);
    hz_md   = md_use_D & md_busy;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      md_start_E <= 1'b0;
      md_div_E   <= 1'b0;
      md_cnt     <= 4'd0;
    end else begin
      md_start_E <= stall ? 1'b0 : md_start_D;
      md_div_E   <= stall ? 1'b0 : md_div_D;
      md_cnt     <= md_start_E ? (md_div_E ? 4'd10 : 4'd5) : md_cnt - {3'd0, md_cnt != 4'd0};
    end
  end
`else
  logic unused_md;
  always_comb begin
    unused_md = ^{md_start_D, md_div_D, md_use_D};
    md_busy   = 1'b0;
    hz_md     = 1'b0;
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed pipeline scenarios plus a random instruction stream checked against a ready-time model.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, wa_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic       md_start_D, md_div_D, md_use_D;
  logic       stall, clr_E, md_busy;
  int total = 0;
  int bad = 0;
  int d_wa [0:1023];
  int d_tn [0:1023];
  int rst_c, md_until, n;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .wa_D(wa_D), .tnew_D(tnew_D),
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
    .stall(stall), .clr_E(clr_E), .md_busy(md_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tr,
                       input logic [1:0] tt, input logic [4:0] wa, input logic [1:0] tn,
                       input logic ms, input logic md, input logic mu);
    rs_D = rs; rt_D = rt; tuse_rs_D = tr; tuse_rt_D = tt; wa_D = wa; tnew_D = tn;
    md_start_D = ms; md_div_D = md; md_use_D = mu;
  endtask
  task automatic nop();
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    nop();
    tick();
    tick();
  endtask
  // A producer seen in D at cycle c-k (not stalled) has its result at c-k+1+tnew; the consumer needs it at c+tuse.
  function automatic bit hz(input int c, input int r, input int tu);
    if (r == 0 || tu == 3) return 1'b0;
    for (int k = 1; k <= 2; k++)
      if (c - k >= rst_c && d_wa[c-k] == r && c - k + 1 + d_tn[c-k] > c + tu) return 1'b1;
    return 1'b0;
  endfunction
`ifdef HAZARD_MD_EN
  task automatic md_run(input string tag, input logic div, input int exp_cycles);
    int cnt;
    drain();
    set_d(0, 0, 3, 3, 0, 0, 1, div, 1);
    tick();
    set_d(0, 0, 3, 3, 2, 1, 0, 0, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, md_busy, stall);
      if (!stall) break;
      cnt++;
      tick();
    end
    chk(tag, cnt, exp_cycles);
    drain();
  endtask
`endif
  initial begin
    reset = 1'b1;
    nop();
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_stall", stall, 0);
    chk("reset_clr", clr_E, 0);
    chk("reset_busy", md_busy, 0);
    drain();
    set_d(0, 0, 3, 3, 1, 2, 0, 0, 0);
    tick();
    set_d(1, 2, 1, 1, 3, 1, 0, 0, 0);
    @(negedge clk);
    chk("lu_addu_stall", stall, 1);
    chk("lu_addu_clr", clr_E, 1);
    tick();
    @(negedge clk);
    chk("lu_addu_release", stall, 0);
    drain();
    set_d(0, 0, 3, 3, 1, 2, 0, 0, 0);
    tick();
    set_d(1, 0, 0, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu_beq_1", stall, 1);
    tick();
    @(negedge clk);
    chk("lu_beq_2", stall, 1);
    tick();
    @(negedge clk);
    chk("lu_beq_3", stall, 0);
    drain();
    set_d(0, 0, 3, 3, 0, 1, 0, 0, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero_reg", stall, 0);
    drain();
    set_d(0, 0, 3, 3, 5, 1, 0, 0, 0);
    tick();
    set_d(0, 5, 3, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("tuse3_unused", stall, 0);
    set_d(5, 0, 1, 3, 0, 0, 0, 0, 0);
    #1;
    chk("tnew_eq_tuse_fwd", stall, 0);
    set_d(5, 5, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rs_rt_both", stall, 1);
    drain();
    set_d(0, 0, 3, 3, 7, 2, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_d(7, 7, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_clears_shadow", stall, 0);
    drain();
`ifdef HAZARD_MD_EN
    md_run("mult_mflo", 1'b0, 6);
    md_run("div_mfhi", 1'b1, 11);
    set_d(0, 0, 3, 3, 0, 0, 1, 1, 1);
    tick();
    nop();
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    set_d(0, 0, 3, 3, 2, 1, 0, 0, 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("md_reset_busy", md_busy, 0);
    chk("md_reset_stall", stall, 0);
    drain();
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rst_c = 0;
    md_until = -1;
    n = 0;
    for (int c = 0; c < 600; c++) begin
      logic es, eb;
      reset = $urandom_range(0, 39) == 0;
      md_start_D = $urandom_range(0, 7) == 0;
      md_div_D = $urandom_range(0, 1);
      md_use_D = md_start_D | ($urandom_range(0, 5) == 0);
      set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 2), md_start_D, md_div_D, md_use_D);
      @(negedge clk);
`ifdef HAZARD_MD_EN
      eb = c <= md_until;
`else
      eb = 1'b0;
`endif
      es = hz(c, rs_D, tuse_rs_D) | hz(c, rt_D, tuse_rt_D) | (md_use_D & eb);
      chk("rnd_stall", stall, es);
      chk("rnd_clr", clr_E, es);
      chk("rnd_busy", md_busy, eb);
      n += int'(es);
      d_wa[c] = es ? 0 : int'(wa_D);
      d_tn[c] = es ? 0 : int'(tnew_D);
      if (!es && md_start_D) md_until = c + 1 + (md_div_D ? 10 : 5);
      if (reset) begin
        rst_c = c + 1;
        md_until = -1;
      end
      tick();
    end
    reset = 1'b0;
    if (n == 0) begin
      total++;
      bad++;
      $error("FAIL rnd_coverage observed=0 expected=nonzero");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
